rtl_simd_adder_stream: RTL and testbench
========================================

Name: rtl_simd_adder_stream

Overview:
- Parametrised successor to the single-lane streaming adder blackbox used in HLS flows.
- Adds LANES independent W-bit two's-complement sums per beat, packed into one vector.
- Sits between two ap_fifo input streams and one ap_fifo output stream, under ap_ctrl_chain block control.
- Beyond the single-lane version, it adds real FIFO handshakes with backpressure, a 2-stage pipeline, a per-transaction element count, and an optional saturating mode.

Parameters:
- W, 11: lane width in bits.
- LANES, 4: lanes per beat; vector width is LANES*W.
- N_ELEM, 8: beats consumed and produced per ap_start transaction (must be at least 1).
- SATURATE, 0: 0 = wrap-around sum; 1 = signed saturation to [-2^(W-1), 2^(W-1)-1].

Ports:
- ap_clk  in  1  clock; all logic is on the rising edge.
- ap_rst_n  in  1  asynchronous, active-low reset.
- ap_ce  in  1  clock enable; when low, all state is frozen.
- ap_start  in  1  start request for one transaction.
- ap_continue  in  1  acknowledge for ap_done.
- ap_done  out  1  transaction complete; held until acknowledged.
- ap_idle  out  1  block is idle.
- ap_ready  out  1  one-cycle pulse when the last input beat is popped.
- a_dout  in  LANES*W  input vector A; lane i is bits [i*W+W-1 : i*W].
- a_empty_n  in  1  A FIFO has data.
- a_read  out  1  pop A.
- b_dout  in  LANES*W  input vector B.
- b_empty_n  in  1  B FIFO has data.
- b_read  out  1  pop B.
- z_din  out  LANES*W  sum vector.
- z_full_n  in  1  Z FIFO has space.
- z_write  out  1  push Z.

Behaviour:
- Reset (async assert, sync release): state IDLE; both pipeline valids 0; counters 0; z_din 0. Outputs: ap_done 0, ap_ready 0, a_read 0, b_read 0, z_write 0, ap_idle 1.
- FSM states:
  - IDLE: ap_start=1 and ap_ce=1 -> RUN; counters cleared.
  - RUN: when the popped count reaches N_ELEM and the written count reaches N_ELEM -> DONE.
  - DONE: ap_continue=1 -> IDLE. Same-cycle ap_start is ignored; start is re-sampled in IDLE.
- ap_idle = (state==IDLE). ap_done = (state==DONE).
- Pipeline: s1 = registered A/B operands; s2 = output register z_din.
  - s2 advances when s2 is empty or (z_full_n=1 and s2 valid).
  - s1 advances when s1 is empty or s2 advances.
- Pop condition: RUN, ap_ce, a_empty_n, b_empty_n, s1 can accept, popped < N_ELEM.
  - a_read and b_read are asserted together with the pop condition.
  - The two FIFOs are never popped independently.
- z_write = ap_ce and s2 valid and z_full_n. The write count increments on each z_write.
- Latency: pop in cycle t -> z_write earliest in cycle t+2. With no stalls, throughput is 1 beat/cycle.
- ap_ready pulses in the cycle of the N_ELEM-th pop. The FSM stays in RUN until the pipeline drains.
- Backpressure: with z_full_n=0, s2 holds its value and z_din is stable. s1 then fills, after which pops stop.
  - No beat is lost or duplicated.
  - z_din must not change while s2 is valid and unwritten.
- Arithmetic per lane:
  - SATURATE=0: (a+b) mod 2^W.
  - SATURATE=1: a (W+1)-bit signed sum, clamped to the W-bit signed range.
  - Lanes are independent; there is no carry between lanes.
- ap_ce=0: no pops, no writes, FSM/counters/pipeline frozen; read/write strobes forced to 0.
- Reset mid-transaction: all in-flight beats are discarded and the FSM returns to IDLE. Already-popped input is not replayed.
- ap_start held high across transactions: a new transaction starts only after DONE -> IDLE, i.e. one idle cycle.

Test Plan:
- Single transaction (N_ELEM=8, both FIFOs always ready, z_full_n=1), lane sums 1+2, 100+200, 1023+1, 0+0 -> eight z_write beats with lanes 3, 300, 1024, 0; first write 2 cycles after the first pop; ap_ready on the 8th pop; ap_done until ap_continue.
- Wrap vs saturate, lane 0 = 1023+1 (W=11):
  - SATURATE=0 -> -1024 (0x400).
  - SATURATE=1 -> 1023.
  - SATURATE=1, -1000+(-100) -> -1024.
- Backpressure: z_full_n=0 for cycles 3-9 -> at most 2 beats in flight, pops stop, z_din stable; after release, all 8 beats appear in order.
- Input starvation: b_empty_n toggles 1/0 each cycle while A is always ready -> a_read is never asserted without b_read; 8 correct beats.
- ap_ce=0 for 4 cycles mid-stream -> no strobes, no state change; output identical to the uninterrupted run, just shifted.
- Reset asserted after the 3rd pop -> immediate idle outputs, ap_idle=1; a following transaction produces 8 correct beats.

Source files
------------

// File: rtl/rtl_simd_adder_stream.sv
// Multi-lane streaming adder between two ap_fifo inputs and one ap_fifo output.
// Uses ap_ctrl_chain block control, a 2-stage pipeline, and per-lane wrap or saturating sums.
module rtl_simd_adder_stream #(
    parameter int unsigned W        = 11,
    parameter int unsigned LANES    = 4,
    parameter int unsigned N_ELEM   = 8,
    parameter int unsigned SATURATE = 0
) (
    input  logic                 ap_clk,
    input  logic                 ap_rst_n,
    input  logic                 ap_ce,
    input  logic                 ap_start,
    input  logic                 ap_continue,
    output logic                 ap_done,
    output logic                 ap_idle,
    output logic                 ap_ready,
    input  logic [LANES*W-1:0]   a_dout,
    input  logic                 a_empty_n,
    output logic                 a_read,
    input  logic [LANES*W-1:0]   b_dout,
    input  logic                 b_empty_n,
    output logic                 b_read,
    output logic [LANES*W-1:0]   z_din,
    input  logic                 z_full_n,
    output logic                 z_write
);

    localparam int unsigned VW = LANES * W;
    localparam int unsigned CW = $clog2(N_ELEM + 1);
    localparam logic [CW-1:0] NE    = CW'(N_ELEM);
    localparam logic [CW-1:0] NE_M1 = CW'(N_ELEM - 1);
    localparam logic [W-1:0]  LANE_MAX = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0]  LANE_MIN = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   popped_q, popped_d;
    logic [CW-1:0]   written_q, written_d;
    logic            s1_valid_q, s1_valid_d;
    logic [VW-1:0]   s1_a_q, s1_a_d;
    logic [VW-1:0]   s1_b_q, s1_b_d;
    logic            s2_valid_q, s2_valid_d;
    logic [VW-1:0]   z_q, z_d;
    logic [VW-1:0]   sum;
    logic            s2_adv;
    logic            s1_adv;
    logic            pop;
    logic            push;

    // Sign-extend to W+1 bits; the sum is out of range exactly when its top two bits differ.
    function automatic logic [W-1:0] lane_add(input logic [W-1:0] a, input logic [W-1:0] b);
        logic signed [W:0] s;
        s = $signed({a[W-1], a}) + $signed({b[W-1], b});
        if ((SATURATE != 0) && (s[W] != s[W-1])) begin
            return s[W] ? LANE_MIN : LANE_MAX;
        end
        return s[W-1:0];
    endfunction

    always_comb begin
        sum = '0;
        for (int i = 0; i < int'(LANES); i++) begin
            sum[i*W +: W] = lane_add(s1_a_q[i*W +: W], s1_b_q[i*W +: W]);
        end
    end

    always_comb begin
        s2_adv = !s2_valid_q || z_full_n;
        s1_adv = !s1_valid_q || s2_adv;
        pop    = ap_ce && (state_q == StRun) && a_empty_n && b_empty_n && s1_adv
                 && (popped_q < NE);
        push   = ap_ce && s2_valid_q && z_full_n;
    end

    always_comb begin
        state_d    = state_q;
        popped_d   = popped_q;
        written_d  = written_q;
        s1_valid_d = s1_valid_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s2_valid_d = s2_valid_q;
        z_d        = z_q;

        if (ap_ce) begin
            if (s2_adv) begin
                s2_valid_d = s1_valid_q;
                if (s1_valid_q) begin
                    z_d = sum;
                end
            end
            if (s1_adv) begin
                s1_valid_d = pop;
                if (pop) begin
                    s1_a_d = a_dout;
                    s1_b_d = b_dout;
                end
            end
            popped_d  = popped_q + CW'(pop);
            written_d = written_q + CW'(push);

            unique case (state_q)
                StIdle: begin
                    if (ap_start) begin
                        state_d   = StRun;
                        popped_d  = '0;
                        written_d = '0;
                    end
                end
                StRun: begin
                    if ((popped_q == NE) && (written_q == NE)) begin
                        state_d = StDone;
                    end
                end
                StDone: begin
                    // A start seen alongside continue is ignored; IDLE re-samples it.
                    if (ap_continue) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q    <= StIdle;
            popped_q   <= '0;
            written_q  <= '0;
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s2_valid_q <= 1'b0;
            z_q        <= '0;
        end else begin
            state_q    <= state_d;
            popped_q   <= popped_d;
            written_q  <= written_d;
            s1_valid_q <= s1_valid_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            s2_valid_q <= s2_valid_d;
            z_q        <= z_d;
        end
    end

    always_comb begin
        ap_idle  = (state_q == StIdle);
        ap_done  = (state_q == StDone);
        ap_ready = pop && (popped_q == NE_M1);
        a_read   = pop;
        b_read   = pop;
        z_write  = push;
        z_din    = z_q;
    end

endmodule

// File: tb/tb_rtl_simd_adder_stream.sv
// Bench for rtl_simd_adder_stream: wrap and saturating instances share one pair of input
// streams and are checked against a queue-based lane-arithmetic model.
module tb_rtl_simd_adder_stream;

    localparam int W     = 11;
    localparam int LANES = 4;
    localparam int N     = 8;
    localparam int VW    = W * LANES;
    localparam int HALF  = 2 ** (W - 1);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ce, start, cont, a_empty_n, b_empty_n, z_full_n;
    logic [VW-1:0] a_dout, b_dout;

    logic done_w, idle_w, ready_w, a_read_w, b_read_w, zwr_w;
    logic done_s, idle_s, ready_s, a_read_s, b_read_s, zwr_s;
    logic [VW-1:0] z_w, z_s;

    always #5 clk = ~clk;

    rtl_simd_adder_stream #(.W(W), .LANES(LANES), .N_ELEM(N), .SATURATE(0)) dut_w (
        .ap_clk(clk), .ap_rst_n(rst_n), .ap_ce(ce), .ap_start(start), .ap_continue(cont),
        .ap_done(done_w), .ap_idle(idle_w), .ap_ready(ready_w),
        .a_dout(a_dout), .a_empty_n(a_empty_n), .a_read(a_read_w),
        .b_dout(b_dout), .b_empty_n(b_empty_n), .b_read(b_read_w),
        .z_din(z_w), .z_full_n(z_full_n), .z_write(zwr_w)
    );

    rtl_simd_adder_stream #(.W(W), .LANES(LANES), .N_ELEM(N), .SATURATE(1)) dut_s (
        .ap_clk(clk), .ap_rst_n(rst_n), .ap_ce(ce), .ap_start(start), .ap_continue(cont),
        .ap_done(done_s), .ap_idle(idle_s), .ap_ready(ready_s),
        .a_dout(a_dout), .a_empty_n(a_empty_n), .a_read(a_read_s),
        .b_dout(b_dout), .b_empty_n(b_empty_n), .b_read(b_read_s),
        .z_din(z_s), .z_full_n(z_full_n), .z_write(zwr_s)
    );

    logic [VW-1:0] src_a[$], src_b[$], exp_w[$], exp_s[$];
    int checks = 0;
    int errors = 0;
    int pops, wr_w, wr_s, tc, mode, first_pop_c, first_wr_c;
    bit running;
    bit const_chk;
    logic [VW-1:0] const_w, const_s;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [VW-1:0] pack(input int l0, input int l1, input int l2,
                                           input int l3);
        logic [VW-1:0] v;
        v[0*W +: W] = W'(l0);
        v[1*W +: W] = W'(l1);
        v[2*W +: W] = W'(l2);
        v[3*W +: W] = W'(l3);
        return v;
    endfunction

    // Reference: per-lane signed integer sum, then truncate or clamp.
    function automatic logic [VW-1:0] model_sum(input logic [VW-1:0] a, input logic [VW-1:0] b,
                                                input bit sat);
        logic [VW-1:0] r;
        r = '0;
        for (int i = 0; i < LANES; i++) begin
            int x, y, s;
            x = int'(a[i*W +: W]);
            y = int'(b[i*W +: W]);
            if (x >= HALF) x -= 2 * HALF;
            if (y >= HALF) y -= 2 * HALF;
            s = x + y;
            if (sat) begin
                if (s > HALF - 1) s = HALF - 1;
                if (s < -HALF) s = -HALF;
            end
            r[i*W +: W] = W'(s);
        end
        return r;
    endfunction

    task automatic fill_directed(input logic [VW-1:0] a, input logic [VW-1:0] b);
        for (int i = 0; i < N; i++) begin
            src_a.push_back(a);
            src_b.push_back(b);
        end
    endtask

    task automatic fill_random();
        for (int i = 0; i < N; i++) begin
            src_a.push_back(VW'({$urandom(), $urandom()}));
            src_b.push_back(VW'({$urandom(), $urandom()}));
        end
    endtask

    task automatic drive_inputs();
        ce        = 1'b1;
        z_full_n  = 1'b1;
        a_empty_n = (src_a.size() > 0);
        b_empty_n = (src_b.size() > 0);
        case (mode)
            1: z_full_n = !(tc >= 3 && tc <= 9);
            2: b_empty_n = b_empty_n && ((tc % 2) == 1);
            3: ce = !(tc >= 4 && tc <= 7);
            4: begin
                a_empty_n = a_empty_n && ($urandom_range(0, 3) != 0);
                b_empty_n = b_empty_n && ($urandom_range(0, 3) != 0);
                z_full_n  = ($urandom_range(0, 2) != 0);
            end
            default: ;
        endcase
        a_dout = (src_a.size() > 0) ? src_a[0] : VW'({$urandom(), $urandom()});
        b_dout = (src_b.size() > 0) ? src_b[0] : VW'({$urandom(), $urandom()});
    endtask

    // One clock: drive at negedge, sample 1ns later, check, then cross the posedge.
    task automatic step();
        logic exp_pop;
        drive_inputs();
        #1;
        // Two beats in flight fill both stages, so the stage-1 slot frees only on a write.
        exp_pop = running && ce && a_empty_n && b_empty_n
                  && (exp_w.size() < 2 || z_full_n) && (pops < N);
        chk("a_read_w", a_read_w, exp_pop);
        chk("b_read_w", b_read_w, exp_pop);
        chk("a_read_s", a_read_s, exp_pop);
        chk("b_read_s", b_read_s, exp_pop);
        chk("ap_ready_w", ready_w, exp_pop && (pops == N - 1));
        chk("ap_ready_s", ready_s, exp_pop && (pops == N - 1));
        if (!ce || !z_full_n) begin
            chk("z_write_gate_w", zwr_w, 1'b0);
            chk("z_write_gate_s", zwr_s, 1'b0);
        end
        if (running && wr_w < N) chk("ap_done_early", done_w, 1'b0);
        if (exp_w.size() == 2) chk("z_hold_w", z_w, exp_w[0]);
        if (exp_s.size() == 2) chk("z_hold_s", z_s, exp_s[0]);

        if (zwr_w) begin
            if (exp_w.size() == 0) chk("z_write_w_unexpected", zwr_w, 1'b0);
            else begin
                if (const_chk && wr_w == 0) chk("z_din_w_const", z_w, const_w);
                chk("z_din_w", z_w, exp_w.pop_front());
                if (wr_w == 0) first_wr_c = tc;
                wr_w++;
            end
        end
        if (zwr_s) begin
            if (exp_s.size() == 0) chk("z_write_s_unexpected", zwr_s, 1'b0);
            else begin
                if (const_chk && wr_s == 0) chk("z_din_s_const", z_s, const_s);
                chk("z_din_s", z_s, exp_s.pop_front());
                wr_s++;
            end
        end
        if (a_read_w && src_a.size() > 0 && src_b.size() > 0) begin
            if (pops == 0) first_pop_c = tc;
            exp_w.push_back(model_sum(src_a[0], src_b[0], 1'b0));
            exp_s.push_back(model_sum(src_a[0], src_b[0], 1'b1));
            void'(src_a.pop_front());
            void'(src_b.pop_front());
            pops++;
        end
        chk("inflight_w", exp_w.size() <= 2, 1'b1);
        @(posedge clk);
        tc++;
        @(negedge clk);
    endtask

    task automatic begin_txn(input int md);
        mode = md;
        tc = 0;
        pops = 0;
        wr_w = 0;
        wr_s = 0;
        first_pop_c = -100;
        first_wr_c = 0;
        start = 1'b1;
        step();
        start = 1'b0;
        running = 1'b1;
    endtask

    task automatic run_txn(input int md);
        int n;
        begin_txn(md);
        n = 0;
        while (!(done_w && done_s) && n < 200) begin
            step();
            n++;
        end
        running = 1'b0;
        chk("ap_done_w", done_w, 1'b1);
        chk("ap_done_s", done_s, 1'b1);
        chk("pops", pops, N);
        chk("writes_w", wr_w, N);
        chk("writes_s", wr_s, N);
    endtask

    task automatic finish_txn(input bit hold_start);
        cont = 1'b0;
        step();
        chk("done_held", done_w, 1'b1);
        chk("idle_in_done", idle_w, 1'b0);
        cont = 1'b1;
        start = hold_start;
        step();
        cont = 1'b0;
        chk("idle_after_cont_w", idle_w, 1'b1);
        chk("idle_after_cont_s", idle_s, 1'b1);
        chk("done_after_cont", done_w, 1'b0);
    endtask

    initial begin
        running = 1'b0;
        const_chk = 1'b0;
        mode = 0;
        tc = 0;
        ce = 1'b1;
        start = 1'b1;
        cont = 1'b0;
        a_empty_n = 1'b1;
        b_empty_n = 1'b1;
        z_full_n = 1'b1;
        a_dout = '1;
        b_dout = '1;
        #12;
        chk("rst_idle", idle_w, 1'b1);
        chk("rst_done", done_w, 1'b0);
        chk("rst_ready", ready_w, 1'b0);
        chk("rst_a_read", a_read_w, 1'b0);
        chk("rst_z_write", zwr_w, 1'b0);
        chk("rst_z_din", z_w, '0);
        chk("rst_idle_s", idle_s, 1'b1);
        @(negedge clk);
        start = 1'b0;
        rst_n = 1'b1;

        // Directed wrap sums: lanes 1+2, 100+200, 1023+1, 0+0.
        fill_directed(pack(1, 100, 1023, 0), pack(2, 200, 1, 0));
        const_chk = 1'b1;
        const_w = pack(3, 300, -1024, 0);
        const_s = pack(3, 300, 1023, 0);
        run_txn(0);
        chk("first_write_latency", first_wr_c - first_pop_c, 2);
        finish_txn(1'b0);

        // Directed saturation corners, then start held high through the acknowledge.
        fill_directed(pack(1023, -1000, 5, -5), pack(1, -100, -7, 3));
        const_w = pack(-1024, 948, -2, -2);
        const_s = pack(1023, -1024, -2, -2);
        run_txn(0);
        const_chk = 1'b0;
        fill_random();
        finish_txn(1'b1);

        run_txn(1);
        finish_txn(1'b0);
        fill_random();
        run_txn(2);
        finish_txn(1'b0);
        fill_random();
        run_txn(3);
        finish_txn(1'b0);
        fill_random();
        run_txn(4);
        finish_txn(1'b0);

        // Reset after the third pop.
        fill_random();
        begin_txn(0);
        for (int n = 0; n < 50 && pops < 3; n++) step();
        chk("abort_pops", pops, 3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_idle_w", idle_w, 1'b1);
        chk("abort_idle_s", idle_s, 1'b1);
        chk("abort_done", done_w, 1'b0);
        chk("abort_a_read", a_read_w, 1'b0);
        chk("abort_b_read", b_read_w, 1'b0);
        chk("abort_z_write", zwr_w, 1'b0);
        chk("abort_z_din", z_w, '0);
        running = 1'b0;
        src_a.delete();
        src_b.delete();
        exp_w.delete();
        exp_s.delete();
        @(negedge clk);
        rst_n = 1'b1;
        fill_random();
        run_txn(0);
        finish_txn(1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
